// File: rtl/vsn_sparam_pkg.sv
// rtl/vsn_sparam_pkg.sv - shared types and helpers for the S-parameter coefficient loader
package vsn_sparam_pkg;

    localparam int NPORTS_DEFAULT     = 3;
    localparam int COEF_WIDTH_DEFAULT = 16;

    typedef logic signed [15:0] coef_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ld_state_t;

    // Bit offset of coefficient (row,col) inside the flattened S_out bus
    function automatic int coef_idx(input logic [1:0] row, input logic [1:0] col);
        return (int'(row) * NPORTS_DEFAULT + int'(col)) * COEF_WIDTH_DEFAULT;
    endfunction

endpackage

// File: rtl/vsn_coef_ramp.sv
// rtl/vsn_coef_ramp.sv - one coefficient's linear ramp datapath (delta + fixed-point accumulator)
module vsn_coef_ramp #(
    parameter int COEF_WIDTH = 16,
    parameter int RAMP_LOG2  = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic signed [COEF_WIDTH-1:0] start,
    input  logic signed [COEF_WIDTH-1:0] target,
    input  logic                         load,
    input  logic                         step,
    output logic signed [COEF_WIDTH-1:0] value
);

    // One guard bit above the scaled coefficient keeps the sum of start<<R and k*delta representable
    localparam int ACCW = COEF_WIDTH + RAMP_LOG2 + 1;

    logic signed [COEF_WIDTH:0] delta_q;
    logic signed [COEF_WIDTH:0] delta_d;
    logic signed [ACCW-1:0]     acc_q;
    logic signed [ACCW-1:0]     acc_start;
    logic signed [ACCW-1:0]     acc_target;
    logic                       acc_unused;

    assign delta_d    = (COEF_WIDTH+1)'(target) - (COEF_WIDTH+1)'(start);
    assign acc_start  = ACCW'(start) <<< RAMP_LOG2;
    assign acc_target = ACCW'(target);

    // Load snapshots the ramp origin and slope; each step advances by one slope increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q   <= '0;
            delta_q <= '0;
        end else if (load) begin
            delta_q <= delta_d;
            acc_q   <= (RAMP_LOG2 == 0) ? acc_target : acc_start;
        end else if (step) begin
            acc_q   <= acc_q + ACCW'(delta_q);
        end
    end

    // Arithmetic shift right by RAMP_LOG2 then truncation is exactly this slice (floor)
    assign value      = acc_q[RAMP_LOG2 +: COEF_WIDTH];
    assign acc_unused = ^acc_q;

endmodule

// File: rtl/vsn_sparam_coef_loader.sv
// rtl/vsn_sparam_coef_loader.sv - shadow-bank S-matrix loader with glitch-free ramped commit
module vsn_sparam_coef_loader
    import vsn_sparam_pkg::*;
#(
    parameter int NPORTS     = NPORTS_DEFAULT,
    parameter int COEF_WIDTH = COEF_WIDTH_DEFAULT,
    parameter int RAMP_LOG2  = 4
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [1:0]                           wr_row,
    input  logic [1:0]                           wr_col,
    input  logic [COEF_WIDTH-1:0]                wr_data,
    input  logic                                 commit_valid,
    output logic                                 commit_ready,
    input  logic                                 err_clear,
    output logic                                 err_addr,
    output logic                                 busy,
    output logic [NPORTS*NPORTS*COEF_WIDTH-1:0]  S_out
);

    localparam int              NCOEF    = NPORTS * NPORTS;
    localparam int              CNTW     = (RAMP_LOG2 > 0) ? RAMP_LOG2 : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << RAMP_LOG2) - 1);
    localparam logic [2:0]      NP3      = 3'(NPORTS);

    ld_state_t       state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q;
    logic            wr_bad;
    logic            wr_ok;
    logic            commit_fire;
    logic            ramp_step;

    assign wr_ready     = 1'b1;
    assign wr_bad       = ({1'b0, wr_row} >= NP3) || ({1'b0, wr_col} >= NP3);
    assign wr_ok        = wr_valid && !wr_bad;
    assign commit_ready = (state_q == IDLE);
    assign commit_fire  = commit_valid && (state_q == IDLE);
    assign ramp_step    = (state_q == RAMP);
    assign busy         = (state_q == RAMP);
    assign err_addr     = err_q;

    // State and ramp-cycle counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a zero-length ramp updates in place and never leaves IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (commit_fire && (RAMP_LOG2 > 0)) begin
                    state_d = RAMP;
                    cnt_d   = '0;
                end
            end
            RAMP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky address error; a new bad write wins over a simultaneous clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (wr_valid && wr_bad) begin
            err_q <= 1'b1;
        end else if (err_clear) begin
            err_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCOEF; i++) begin : g_coef
        localparam int ROW = i / NPORTS;
        localparam int COL = i % NPORTS;

        logic                         hit;
        logic        [COEF_WIDTH-1:0] shadow_q;
        logic signed [COEF_WIDTH-1:0] target;
        logic signed [COEF_WIDTH-1:0] live;

        assign hit    = wr_ok && (wr_row == 2'(ROW)) && (wr_col == 2'(COL));
        // A write in the commit cycle is forwarded so the snapshot sees it
        assign target = hit ? wr_data : shadow_q;

        // Shadow coefficient storage, invisible to S_out until a commit
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                shadow_q <= '0;
            end else if (hit) begin
                shadow_q <= wr_data;
            end
        end

        vsn_coef_ramp #(
            .COEF_WIDTH (COEF_WIDTH),
            .RAMP_LOG2  (RAMP_LOG2)
        ) u_ramp (
            .clk    (clk),
            .resetn (resetn),
            .start  (live),
            .target (target),
            .load   (commit_fire),
            .step   (ramp_step),
            .value  (live)
        );

        assign S_out[i*COEF_WIDTH +: COEF_WIDTH] = live;
    end

endmodule

// File: tb/tb_vsn_sparam_coef_loader.sv
// tb/tb_vsn_sparam_coef_loader.sv - directed scoreboard bench for the S-matrix coefficient loader
module tb_vsn_sparam_coef_loader;
    import vsn_sparam_pkg::*;

    localparam int NP    = 3;
    localparam int W     = 16;
    localparam int RL    = 2;
    localparam int NSTEP = 1 << RL;
    localparam int VW    = NP * NP * W;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [1:0]    wr_row = '0;
    logic [1:0]    wr_col = '0;
    logic [W-1:0]  wr_data = '0;
    logic          commit_valid = 1'b0;
    logic          commit_ready;
    logic          err_clear = 1'b0;
    logic          err_addr;
    logic          busy;
    logic [VW-1:0] S_out;

    always #5 clk = ~clk;

    vsn_sparam_coef_loader #(
        .NPORTS     (NP),
        .COEF_WIDTH (W),
        .RAMP_LOG2  (RL)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .err_clear    (err_clear),
        .err_addr     (err_addr),
        .busy         (busy),
        .S_out        (S_out)
    );

    typedef struct {
        string         tag;
        logic [VW-1:0] v;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [VW-1:0] shadow_m = '0;
    logic [VW-1:0] live_m = '0;
    logic [VW-1:0] start_m = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] ramp_vec(input logic [VW-1:0] s, input logic [VW-1:0] t, input int k);
        logic [VW-1:0] r;
        int sv, tv, a;
        r = '0;
        for (int i = 0; i < NP*NP; i++) begin
            sv = int'($signed(s[i*W +: W]));
            tv = int'($signed(t[i*W +: W]));
            a  = (sv * NSTEP + (tv - sv) * k) >>> RL;
            r[i*W +: W] = a[W-1:0];
        end
        return r;
    endfunction

    task automatic set_wr(input logic [1:0] r, input logic [1:0] c, input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_row   = r;
        wr_col   = c;
        wr_data  = d;
        if (r < 2'd3 && c < 2'd3) shadow_m[coef_idx(r, c) +: W] = d;
    endtask

    task automatic clr_wr();
        wr_valid = 1'b0;
    endtask

    // Raise commit and queue the four expected ramp points from the current model state
    task automatic start_commit(input string tag);
        exp_t e;
        commit_valid = 1'b1;
        start_m = live_m;
        for (int k = 1; k <= NSTEP; k++) begin
            e.tag = $sformatf("%s_step%0d", tag, k);
            e.v   = ramp_vec(live_m, shadow_m, k);
            sb.push_back(e);
        end
        live_m = shadow_m;
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, S_out, e.v);
        end
    endtask

    // Called in cycle T+1 after the commit edge
    task automatic ramp_body(input string tag);
        chk1({tag, "_busy_start"}, busy, 1'b1);
        chk({tag, "_hold_start"}, S_out, start_m);
        for (int k = 1; k <= NSTEP; k++) begin
            tick();
            pop_chk();
            chk1($sformatf("%s_busy%0d", tag, k), busy, (k < NSTEP));
        end
    endtask

    initial begin
        // 1: reset and idle
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_sout", S_out, '0);
        chk1("rst_wr_ready", wr_ready, 1'b1);
        chk1("rst_commit_ready", commit_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err_addr, 1'b0);

        // 2: shadow writes stay hidden until commit, then ramp
        set_wr(2'd0, 2'd0, 16'h4000);
        tick();
        set_wr(2'd1, 2'd2, 16'hC000);
        tick();
        clr_wr();
        for (int i = 0; i < 10; i++) tick();
        chk("shadow_hidden", S_out, '0);
        start_commit("t2");
        tick();
        commit_valid = 1'b0;
        ramp_body("t2");
        chk("t2_s00_final", VW'(S_out[coef_idx(2'd0, 2'd0) +: W]), VW'(16'h4000));
        chk("t2_s12_final", VW'(S_out[coef_idx(2'd1, 2'd2) +: W]), VW'(16'hC000));

        // 3: commit held during a ramp stalls, then is accepted as busy falls
        start_commit("t3a");
        tick();
        for (int k = 1; k <= NSTEP; k++) begin
            chk1($sformatf("t3_stall_ready%0d", k), commit_ready, 1'b0);
            tick();
            pop_chk();
        end
        chk1("t3_ready_after", commit_ready, 1'b1);
        chk1("t3_busy_gap", busy, 1'b0);
        start_commit("t3b");
        tick();
        commit_valid = 1'b0;
        ramp_body("t3b");

        // 4: out-of-range writes and the sticky error flag
        set_wr(2'd3, 2'd0, 16'h1234);
        tick();
        clr_wr();
        chk1("t4_err_set", err_addr, 1'b1);
        start_commit("t4");
        tick();
        commit_valid = 1'b0;
        ramp_body("t4");
        err_clear = 1'b1;
        set_wr(2'd0, 2'd3, 16'h5555);
        tick();
        clr_wr();
        err_clear = 1'b0;
        chk1("t4_err_set_wins", err_addr, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk1("t4_err_cleared", err_addr, 1'b0);
        chk("t4_sout_kept", S_out, live_m);

        // 5: write in the commit cycle is part of the snapshot
        set_wr(2'd2, 2'd2, 16'h7FFF);
        start_commit("t5");
        tick();
        clr_wr();
        commit_valid = 1'b0;
        ramp_body("t5");
        chk("t5_s22_final", VW'(S_out[coef_idx(2'd2, 2'd2) +: W]), VW'(16'h7FFF));

        // 6: asynchronous reset mid-ramp
        set_wr(2'd0, 2'd1, 16'h0100);
        tick();
        clr_wr();
        start_commit("t6");
        tick();
        commit_valid = 1'b0;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_async_sout", S_out, '0);
        chk1("t6_async_busy", busy, 1'b0);
        sb.delete();
        shadow_m = '0;
        live_m   = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        start_commit("t6post");
        tick();
        commit_valid = 1'b0;
        ramp_body("t6post");
        chk("t6_sout_zero", S_out, '0);
        chk1("t6_commit_ready", commit_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
